fifo_burst_controller: RTL

Read-side sequencer for the 8192 × 10-bit sample FIFO, running in the FIFO read (USB host) clock domain. It waits until the FIFO holds at least a full burst, then drains exactly BURST_WORDS samples to the FX3 host interface as 16-bit words, honouring host back-pressure. It also tracks overflow and underrun conditions and counts completed bursts.

---
 rtl/fifo_burst_pkg.sv | 28 ++
 rtl/fifo_burst_controller.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fifo_burst_pkg.sv
// fifo_burst_pkg
// Shared types and sizing for the sample-FIFO read-side burst sequencer.
//   state_e      : sequencer states (IDLE, WAIT_FILL, BURST)
//   SAMPLE_WIDTH : width of one ADC sample as stored in the FIFO
//   HOST_WIDTH   : width of one word on the FX3 host interface
//   FIFO_DEPTH   : sample FIFO depth in words
//   HALF_LEVEL   : level above which the FIFO half-full flag is raised
//   COUNT_WIDTH  : width of the completed-burst counter
//   pack_sample  : zero-extends a sample to a host word
package fifo_burst_pkg;

  localparam int SAMPLE_WIDTH = 10;
  localparam int HOST_WIDTH   = 16;
  localparam int FIFO_DEPTH   = 8192;
  localparam int HALF_LEVEL   = FIFO_DEPTH / 2;
  localparam int COUNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    BURST     = 2'd2
  } state_e;

  function automatic logic [HOST_WIDTH-1:0] pack_sample(input logic [SAMPLE_WIDTH-1:0] sample);
    return {{(HOST_WIDTH - SAMPLE_WIDTH){1'b0}}, sample};
  endfunction

endpackage

// File: rtl/fifo_burst_controller.sv
// fifo_burst_controller
// Read-side sequencer for the 8192 x 10-bit sample FIFO, in the FIFO read
// (USB host) clock domain. Waits for the FIFO to hold a full burst, then
// drains exactly BURST_WORDS samples to the host as 16-bit words, honouring
// host back-pressure. Tracks overflow/underrun and counts completed bursts.
//
// Ports
//   i_clock            FIFO read clock, rising edge
//   i_reset            synchronous, active-high
//   i_enable           capture running (level)
//   i_host_ready       host accepts a word this cycle
//   i_fifo_data        show-ahead FIFO output, valid when i_fifo_empty=0
//   i_fifo_empty       registered FIFO empty flag
//   i_fifo_half_full   registered FIFO half-full flag (level > HALF_LEVEL)
//   i_fifo_full        registered FIFO full flag
//   o_fifo_ack         FIFO read request, combinational, pops current word
//   o_data_out         {6'b0, sample}, registered
//   o_data_valid       o_data_out holds a new word this cycle
//   o_burst_end        last word of a burst, coincides with o_data_valid
//   o_overflow         sticky, FIFO reported full during capture
//   o_underrun         sticky, FIFO went empty inside a burst
//   o_burst_count      completed bursts, wraps
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | capture stopped; no reads; flags/counter held
// WAIT_FILL | waiting for half-full and a ready host before starting a burst
// BURST     | popping one word per cycle while host ready and FIFO not empty
module fifo_burst_controller
  import fifo_burst_pkg::*;
#(
  parameter int BURST_WORDS = HALF_LEVEL
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_enable,
  input  logic                    i_host_ready,
  input  logic [SAMPLE_WIDTH-1:0] i_fifo_data,
  input  logic                    i_fifo_empty,
  input  logic                    i_fifo_half_full,
  input  logic                    i_fifo_full,
  output logic                    o_fifo_ack,
  output logic [HOST_WIDTH-1:0]   o_data_out,
  output logic                    o_data_valid,
  output logic                    o_burst_end,
  output logic                    o_overflow,
  output logic                    o_underrun,
  output logic [COUNT_WIDTH-1:0]  o_burst_count
);

  localparam int REM_WIDTH = $clog2(BURST_WORDS + 1);

  state_e                 r_state;
  logic [REM_WIDTH-1:0]   r_remaining;
  logic [HOST_WIDTH-1:0]  r_data_out;
  logic                   r_data_valid;
  logic                   r_burst_end;
  logic                   r_overflow;
  logic                   r_underrun;
  logic [COUNT_WIDTH-1:0] r_burst_count;

  logic w_pop;
  logic w_last;

  // Dropping enable must kill the read request in the same cycle, so the
  // enable term sits directly in the combinational pop.
  assign w_pop  = (r_state == BURST) && i_enable && i_host_ready && !i_fifo_empty;
  assign w_last = (r_remaining == REM_WIDTH'(1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= IDLE;
      r_remaining   <= '0;
      r_data_out    <= '0;
      r_data_valid  <= 1'b0;
      r_burst_end   <= 1'b0;
      r_overflow    <= 1'b0;
      r_underrun    <= 1'b0;
      r_burst_count <= '0;
    end else begin
      r_data_valid <= 1'b0;
      r_burst_end  <= 1'b0;
      if (!i_enable) begin
        // Abandon any burst; flags and counter stay visible until re-enable.
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            r_state       <= WAIT_FILL;
            r_overflow    <= 1'b0;
            r_underrun    <= 1'b0;
            r_burst_count <= '0;
          end
          WAIT_FILL: begin
            if (i_fifo_full) r_overflow <= 1'b1;
            if (i_fifo_half_full && i_host_ready) begin
              r_remaining <= REM_WIDTH'(BURST_WORDS);
              r_state     <= BURST;
            end
          end
          BURST: begin
            if (i_fifo_full) r_overflow <= 1'b1;
            // Underrun only counts when the host actually wanted a word.
            if (i_host_ready && i_fifo_empty) r_underrun <= 1'b1;
            if (w_pop) begin
              r_data_out   <= pack_sample(i_fifo_data);
              r_data_valid <= 1'b1;
              if (r_remaining != '0) r_remaining <= r_remaining - REM_WIDTH'(1);
              if (w_last) begin
                r_burst_end   <= 1'b1;
                r_burst_count <= r_burst_count + COUNT_WIDTH'(1);
                r_state       <= WAIT_FILL;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_fifo_ack    = w_pop;
  assign o_data_out    = r_data_out;
  assign o_data_valid  = r_data_valid;
  assign o_burst_end   = r_burst_end;
  assign o_overflow    = r_overflow;
  assign o_underrun    = r_underrun;
  assign o_burst_count = r_burst_count;

endmodule
